// File: rtl/four_bit_serial_sub_if.sv
// Request/response bundle for the bit-serial subtractor: operands and start in,
// busy/done status and the held difference/borrow out, plus an FSM state tap.
interface four_bit_serial_sub_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             bout;
    logic [1:0]       state_dbg;

    // Handshake: start is accepted only when busy=0 (IDLE) or in the done cycle;
    // a, b, bin are sampled at that accepting edge only; done is a one-cycle
    // pulse marking d/bout valid, and d/bout hold until the next result.
    modport master (
        output start, a, b, bin,
        input  busy, done, d, bout, state_dbg
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, d, bout, state_dbg
    );
endinterface

// File: rtl/four_bit_serial_sub.sv
// Bit-serial subtractor: d = a - b - bin, one bit per clock LSB first, with a
// start/busy/done handshake; the result is published in one step at completion.
module four_bit_serial_sub #(
    parameter int WIDTH = 4
) (
    input logic                 clk,
    input logic                 rst,
    four_bit_serial_sub_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] res_r;
    logic [WIDTH-1:0] d_r;
    logic             br;
    logic             bout_r;
    logic [CW-1:0]    cnt;
    logic             accept;
    logic             last;
    logic             diff_bit;
    logic             br_next;
    logic [WIDTH-1:0] res_next;
    logic             busy_c;
    logic             done_c;

    assign accept   = bus.start && ((state == IDLE) || (state == DONE));
    assign last     = (cnt == CW'(WIDTH - 1));
    // Operands shift right so bit i is always at [0]; the result fills from the
    // top, so after WIDTH shifts the bit produced on step i sits at position i.
    assign diff_bit = a_r[0] ^ b_r[0] ^ br;
    assign br_next  = (~a_r[0] & b_r[0]) | (~(a_r[0] ^ b_r[0]) & br);
    assign res_next = {diff_bit, res_r[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = SHIFT;
            SHIFT:   if (last) state_next = DONE;
            DONE:    state_next = bus.start ? SHIFT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy_c = 1'b0;
        done_c = 1'b0;
        case (state)
            SHIFT:   busy_c = 1'b1;
            DONE:    done_c = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_r    <= '0;
            b_r    <= '0;
            res_r  <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            d_r    <= '0;
            bout_r <= 1'b0;
        end else if (accept) begin
            a_r   <= bus.a;
            b_r   <= bus.b;
            br    <= bus.bin;
            res_r <= '0;
            cnt   <= '0;
        end else if (state == SHIFT) begin
            a_r   <= a_r >> 1;
            b_r   <= b_r >> 1;
            br    <= br_next;
            res_r <= res_next;
            cnt   <= cnt + 1'b1;
            if (last) begin
                d_r    <= res_next;
                bout_r <= br_next;
            end
        end
    end

    assign bus.busy      = busy_c;
    assign bus.done      = done_c;
    assign bus.d         = d_r;
    assign bus.bout      = bout_r;
    assign bus.state_dbg = state;
endmodule

// File: tb/tb_four_bit_serial_sub.sv
// Self-checking bench for four_bit_serial_sub: expected {bout,d} pushed when a
// start is issued, compared when done pulses.
module tb_four_bit_serial_sub;
    localparam int WIDTH = 4;
    localparam int RW    = WIDTH + 1;

    logic clk = 1'b0;
    logic rst;
    int   checks    = 0;
    int   failures  = 0;
    int   done_cnt  = 0;
    int   start_cnt = 0;
    int   cyc       = 0;

    logic [RW-1:0] exp_q[$];
    logic [RW-1:0] got_q[$];
    int            done_cyc_q[$];

    always #5 clk = ~clk;

    four_bit_serial_sub_if #(.WIDTH(WIDTH)) bus ();

    four_bit_serial_sub #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always @(posedge clk) cyc++;

    // Collect every result the DUT publishes, mid-cycle.
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            got_q.push_back({bus.bout, bus.d});
            done_cyc_q.push_back(cyc);
            done_cnt++;
        end
    end

    function automatic logic [RW-1:0] model(input int av, input int bv, input int binv);
        logic [RW-1:0] x;
        x = RW'(av) - RW'(bv) - RW'(binv);
        return x;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic start_op(input int av, input int bv, input int binv, input bit expect_result);
        bus.start = 1'b1;
        bus.a     = WIDTH'(av);
        bus.b     = WIDTH'(bv);
        bus.bin   = binv[0];
        if (expect_result) begin
            exp_q.push_back(model(av, bv, binv));
            start_cnt++;
        end
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_result(input string name, output bit ok,
                               output logic [RW-1:0] got, output logic [RW-1:0] exp);
        int n;
        n   = 0;
        ok  = 1'b0;
        got = '0;
        exp = '0;
        while (got_q.size() == 0 && n < 40) begin
            tick();
            n++;
        end
        if (got_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: no done pulse within 40 cycles", name);
        end else begin
            got = got_q.pop_front();
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL %s: done pulse with no outstanding request, d=%0d bout=%0d",
                         name, got[WIDTH-1:0], got[WIDTH]);
            end else begin
                exp = exp_q.pop_front();
                ok  = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.bin   = 1'b0;
        repeat (3) tick();
        checks++;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++;
        if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", bus.done); end
        checks++;
        if (bus.d !== '0) begin failures++; $display("FAIL reset_d: got %0d want 0", bus.d); end
        checks++;
        if (bus.bout !== 1'b0) begin failures++; $display("FAIL reset_bout: got %b want 0", bus.bout); end
        checks++;
        if (bus.state_dbg !== 2'd0) begin failures++; $display("FAIL reset_state: got %0d want 0", bus.state_dbg); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int busy_n;
        int base;
        bit ok;
        logic [RW-1:0] got, exp;
        busy_n = 0;
        base   = done_cnt;
        start_op(11, 15, 0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            if (bus.busy === 1'b1) busy_n++;
            tick();
        end
        checks++;
        if (busy_n !== WIDTH) begin failures++; $display("FAIL basic_busy_cycles: got %0d want %0d", busy_n, WIDTH); end
        checks++;
        if (done_cnt - base !== 1) begin failures++; $display("FAIL basic_done_pulses: got %0d want 1", done_cnt - base); end
        wait_result("basic", ok, got, exp);
        if (ok) begin
            checks++;
            if (got !== exp || got !== 5'b11100) begin
                failures++;
                $display("FAIL basic_result: got d=%0d bout=%0d want d=12 bout=1", got[WIDTH-1:0], got[WIDTH]);
            end
        end
    endtask

    task automatic test_values();
        int tab[3][3] = '{'{15, 0, 0}, '{9, 3, 0}, '{0, 0, 1}};
        bit ok;
        logic [RW-1:0] got, exp;
        for (int i = 0; i < 3; i++) begin
            start_op(tab[i][0], tab[i][1], tab[i][2], 1'b1);
            wait_result("values", ok, got, exp);
            if (ok) begin
                checks++;
                if (got !== exp) begin
                    failures++;
                    $display("FAIL values_%0d: got d=%0d bout=%0d want d=%0d bout=%0d",
                             i, got[WIDTH-1:0], got[WIDTH], exp[WIDTH-1:0], exp[WIDTH]);
                end
            end
            tick();
        end
    endtask

    task automatic test_ignore_busy_start();
        int base;
        bit ok;
        logic [RW-1:0] got, exp;
        base = done_cnt;
        start_op(9, 3, 0, 1'b1);
        for (int i = 0; i < WIDTH - 1; i++) begin
            bus.start = 1'b1;
            bus.a     = (i == 0) ? WIDTH'(1) : WIDTH'($urandom_range(0, 15));
            bus.b     = (i == 0) ? WIDTH'(2) : WIDTH'($urandom_range(0, 15));
            bus.bin   = 1'($urandom_range(0, 1));
            tick();
        end
        bus.start = 1'b0;
        wait_result("ignore", ok, got, exp);
        if (ok) begin
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL ignore_result: got d=%0d bout=%0d want d=%0d bout=%0d",
                         got[WIDTH-1:0], got[WIDTH], exp[WIDTH-1:0], exp[WIDTH]);
            end
        end
        repeat (8) tick();
        checks++;
        if (done_cnt - base !== 1) begin failures++; $display("FAIL ignore_done_pulses: got %0d want 1", done_cnt - base); end
    endtask

    task automatic test_back_to_back();
        int n;
        bit ok;
        logic [RW-1:0] got, exp;
        done_cyc_q.delete();
        bus.start = 1'b1;
        bus.a     = WIDTH'(7);
        bus.b     = WIDTH'(7);
        bus.bin   = 1'b0;
        exp_q.push_back(model(7, 7, 0));
        start_cnt++;
        tick();
        bus.a = WIDTH'(2);
        bus.b = WIDTH'(5);
        exp_q.push_back(model(2, 5, 0));
        start_cnt++;
        repeat (WIDTH + 1) tick();
        bus.start = 1'b0;
        n = 0;
        while (done_cyc_q.size() < 2 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (done_cyc_q.size() !== 2) begin
            failures++;
            $display("FAIL b2b_done_count: got %0d want 2", done_cyc_q.size());
        end else begin
            checks++;
            if (done_cyc_q[1] - done_cyc_q[0] !== WIDTH + 1) begin
                failures++;
                $display("FAIL b2b_gap: got %0d want %0d", done_cyc_q[1] - done_cyc_q[0], WIDTH + 1);
            end
        end
        for (int i = 0; i < 2; i++) begin
            wait_result("b2b", ok, got, exp);
            if (ok) begin
                checks++;
                if (got !== exp) begin
                    failures++;
                    $display("FAIL b2b_result_%0d: got d=%0d bout=%0d want d=%0d bout=%0d",
                             i, got[WIDTH-1:0], got[WIDTH], exp[WIDTH-1:0], exp[WIDTH]);
                end
            end
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int base;
        bit ok;
        logic [RW-1:0] got, exp;
        base = done_cnt;
        start_op(9, 3, 0, 1'b0);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
        checks++;
        if (bus.done !== 1'b0) begin failures++; $display("FAIL midrst_done: got %b want 0", bus.done); end
        checks++;
        if (bus.d !== '0) begin failures++; $display("FAIL midrst_d: got %0d want 0", bus.d); end
        checks++;
        if (bus.bout !== 1'b0) begin failures++; $display("FAIL midrst_bout: got %b want 0", bus.bout); end
        repeat (8) tick();
        checks++;
        if (done_cnt !== base) begin failures++; $display("FAIL midrst_no_done: got %0d pulses want 0", done_cnt - base); end
        start_op(5, 2, 1, 1'b1);
        wait_result("midrst_after", ok, got, exp);
        if (ok) begin
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL midrst_after: got d=%0d bout=%0d want d=%0d bout=%0d",
                         got[WIDTH-1:0], got[WIDTH], exp[WIDTH-1:0], exp[WIDTH]);
            end
        end
        tick();
    endtask

    task automatic test_sweep();
        bit ok;
        logic [RW-1:0] got, exp;
        for (int ai = 0; ai < (1 << WIDTH); ai++) begin
            for (int bi = 0; bi < (1 << WIDTH); bi++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    start_op(ai, bi, ci, 1'b1);
                    wait_result("sweep", ok, got, exp);
                    if (ok) begin
                        checks++;
                        if (got !== exp) begin
                            failures++;
                            $display("FAIL sweep a=%0d b=%0d bin=%0d: got d=%0d bout=%0d want d=%0d bout=%0d",
                                     ai, bi, ci, got[WIDTH-1:0], got[WIDTH], exp[WIDTH-1:0], exp[WIDTH]);
                        end
                    end
                end
            end
        end
        repeat (4) tick();
        checks++;
        if (done_cnt !== start_cnt) begin
            failures++;
            $display("FAIL done_vs_start: got %0d dones want %0d", done_cnt, start_cnt);
        end
        checks++;
        if (exp_q.size() !== 0) begin
            failures++;
            $display("FAIL pending_results: got %0d outstanding want 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_values();
        test_ignore_busy_start();
        test_back_to_back();
        test_reset_mid();
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
